// File: rtl/pkt_chk_if.sv
// pkt_chk_if: beat stream, configuration and status bundle for the packet checker.
// The checker takes the slave modport; whatever feeds the RX stream takes master.
interface pkt_chk_if #(
    parameter int DIN_WIDTH = 32,
    parameter int PARALLEL  = 4
);
    // Receive stream and run-time configuration
    logic                            en;
    logic [DIN_WIDTH*PARALLEL-1:0]   din;
    logic                            din_valid;
    logic [31:0]                     burst_len;

    // Status and counters for software readout
    logic [31:0]                     pkt_count;
    logic [31:0]                     data_err_count;
    logic [31:0]                     len_err_count;
    logic                            err_flag;
    logic                            state_busy;
    logic [31:0]                     err_beat;
    logic [DIN_WIDTH*PARALLEL-1:0]   err_din;

    modport master (
        output en, din, din_valid, burst_len,
        input  pkt_count, data_err_count, len_err_count,
        input  err_flag, state_busy, err_beat, err_din
    );

    modport slave (
        input  en, din, din_valid, burst_len,
        output pkt_count, data_err_count, len_err_count,
        output err_flag, state_busy, err_beat, err_din
    );
endinterface

// File: rtl/pkt_chk.sv
// pkt_chk: receive-side checker for the 10GbE packet test stream.
// A packet is one header beat (every lane == HEADER) followed by burst_len+1
// beats of lane counters. Framing, length and data content are checked and
// running packet / data-error / length-error counters are kept.
// Optional feature macro: PKT_CHK_ERR_CAPTURE_EN -- when defined, the beat
// index and din of the first data error after reset are latched into
// err_beat / err_din; otherwise both outputs are tied to zero.
module pkt_chk #(
    parameter int          DIN_WIDTH = 32,
    parameter int          PARALLEL  = 4,
    parameter logic [31:0] HEADER    = 32'hAABBCCDD
) (
    input logic      clk,
    input logic      rst,
    pkt_chk_if.slave bus
);
    localparam int                   BUS_W     = DIN_WIDTH * PARALLEL;
    // Header word zero-extended or truncated to the lane width
    localparam logic [DIN_WIDTH-1:0] HDR_WORD  = DIN_WIDTH'(HEADER);
    // Each lane's counter advances by the lane count every beat
    localparam logic [DIN_WIDTH-1:0] LANE_STEP = DIN_WIDTH'(PARALLEL);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        busy_q;
    // One bit wider than burst_len so burst_len+1 never aliases to 0
    logic [32:0] beat_cnt_q;
    logic [31:0] pkt_cnt_q;
    logic [31:0] data_err_cnt_q;
    logic [31:0] len_err_cnt_q;
    logic        err_flag_q;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    logic [PARALLEL-1:0] lane_is_hdr;
    logic [PARALLEL-1:0] lane_mis;
    logic                beat_acc;
    logic                hdr_beat;
    logic [32:0]         burst_end;
    logic                at_end;
    logic                in_burst;
    logic                data_beat;
    logic                data_err_ev;
    logic                rearm;
    logic [32:0]         beat_cnt_d;
    logic [31:0]         pkt_cnt_d;
    logic [31:0]         data_err_cnt_d;
    logic [31:0]         len_err_cnt_d;

    assign beat_acc    = bus.en && bus.din_valid;
    assign hdr_beat    = beat_acc && (&lane_is_hdr);
    assign burst_end   = {1'b0, bus.burst_len} + 33'd1;
    assign at_end      = (beat_cnt_q == burst_end);
    // burst_len is read live, so a mid-packet change applies to the next beat
    assign in_burst    = (beat_cnt_q <= {1'b0, bus.burst_len});
    assign data_beat   = (state_q == ST_DATA) && beat_acc && !hdr_beat && in_burst;
    assign data_err_ev = data_beat && (|lane_mis);
    // A header restarts the expectation from either state
    assign rearm       = hdr_beat;

    assign beat_cnt_d     = beat_cnt_q + 33'd1;
    assign pkt_cnt_d      = pkt_cnt_q + 32'd1;
    assign data_err_cnt_d = data_err_cnt_q + 32'd1;
    assign len_err_cnt_d  = len_err_cnt_q + 32'd1;

    // ------------------------------------------------------------------
    // Per-lane expectation and comparison
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PARALLEL; gi++) begin : g_lane
            logic [DIN_WIDTH-1:0] lane;
            logic [DIN_WIDTH-1:0] exp_q;
            logic [DIN_WIDTH-1:0] exp_d;

            assign lane            = bus.din[DIN_WIDTH*gi +: DIN_WIDTH];
            assign exp_d           = exp_q + LANE_STEP;
            assign lane_is_hdr[gi] = (lane == HDR_WORD);
            assign lane_mis[gi]    = (lane != exp_q);

            // Expectation restarts at the lane index on a header and steps
            // from its own previous value (not the received data) so a
            // corrupted beat does not derail the following comparisons.
            always_ff @(posedge clk) begin
                if (rst) begin
                    exp_q <= '0;
                end else if (rearm) begin
                    exp_q <= DIN_WIDTH'(gi);
                end else if (data_beat) begin
                    exp_q <= exp_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Framing FSM with registered counters, sticky flag and busy output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_HUNT;
            busy_q         <= 1'b0;
            beat_cnt_q     <= '0;
            pkt_cnt_q      <= '0;
            data_err_cnt_q <= '0;
            len_err_cnt_q  <= '0;
            err_flag_q     <= 1'b0;
        end else if (bus.en) begin
            case (state_q)
                ST_HUNT: begin
                    // Everything but a header is discarded while hunting
                    if (hdr_beat) begin
                        state_q    <= ST_DATA;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end

                ST_DATA: begin
                    if (hdr_beat) begin
                        // Back-to-back: the new header closes the current packet
                        if (at_end) begin
                            pkt_cnt_q <= pkt_cnt_d;
                        end else begin
                            len_err_cnt_q <= len_err_cnt_d;
                            err_flag_q    <= 1'b1;
                        end
                        beat_cnt_q <= '0;
                    end else if (bus.din_valid) begin
                        if (in_burst) begin
                            if (data_err_ev) begin
                                data_err_cnt_q <= data_err_cnt_d;
                                err_flag_q     <= 1'b1;
                            end
                            beat_cnt_q <= beat_cnt_d;
                        end else begin
                            // Packet ran past its burst: drop it and resync
                            len_err_cnt_q <= len_err_cnt_d;
                            err_flag_q    <= 1'b1;
                            state_q       <= ST_HUNT;
                            busy_q        <= 1'b0;
                        end
                    end else begin
                        // Gap: ends the packet unless it sits right after the header
                        if (at_end) begin
                            pkt_cnt_q <= pkt_cnt_d;
                            state_q   <= ST_HUNT;
                            busy_q    <= 1'b0;
                        end else if (beat_cnt_q != 33'd0) begin
                            len_err_cnt_q <= len_err_cnt_d;
                            err_flag_q    <= 1'b1;
                            state_q       <= ST_HUNT;
                            busy_q        <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_HUNT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pkt_count      = pkt_cnt_q;
    assign bus.data_err_count = data_err_cnt_q;
    assign bus.len_err_count  = len_err_cnt_q;
    assign bus.err_flag       = err_flag_q;
    assign bus.state_busy     = busy_q;

    // ------------------------------------------------------------------
    // First-error capture
    // ------------------------------------------------------------------
`ifdef PKT_CHK_ERR_CAPTURE_EN
    logic             captured_q;
    logic [31:0]      err_beat_q;
    logic [BUS_W-1:0] err_din_q;

    // Latch index and data of the first failing beat; hold until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            captured_q <= 1'b0;
            err_beat_q <= '0;
            err_din_q  <= '0;
        end else if (data_err_ev && !captured_q) begin
            captured_q <= 1'b1;
            err_beat_q <= beat_cnt_q[31:0];
            err_din_q  <= bus.din;
        end
    end

    assign bus.err_beat = err_beat_q;
    assign bus.err_din  = err_din_q;
`else
    assign bus.err_beat = 32'd0;
    assign bus.err_din  = {BUS_W{1'b0}};
`endif

endmodule
